// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared entry layout and opcode constants for the instruction queue
package inst_queue_pkg;

  localparam int IQ_ENTRY_W = 64;
  localparam int IQ_PC_LSB  = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/inst_queue_iq_ram.sv
// rtl/inst_queue_iq_ram.sv - DEPTH x IQ_ENTRY_W register array, one write port, one async read port
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH_LOG = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG-1:0]  waddr,
  input  logic [IQ_ENTRY_W-1:0] wdata,
  input  logic [DEPTH_LOG-1:0]  raddr,
  output logic [IQ_ENTRY_W-1:0] rdata
);

  logic [IQ_ENTRY_W-1:0] mem [1<<DEPTH_LOG];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular fetch-to-issue instruction FIFO with redirect forwarding and flush
// Optional IQUEUE_BYPASS_EN: an empty queue hands the incoming pair straight to the outputs.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH_LOG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        inst_rdy,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  output logic        iqueue_full,
  output logic [31:0] fetch_pc,
  input  logic        br_done,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic        iss_stall,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_C   = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] FULL_MARK = (DEPTH_LOG+1)'(DEPTH-2);

  logic [DEPTH_LOG-1:0]  head, tail, head_nxt;
  logic [DEPTH_LOG:0]    count, count_nxt, count_after_rd;
  logic                  rd, wr, load, ram_we;
  logic [IQ_ENTRY_W-1:0] ram_rdata, in_entry, load_entry;

  assign in_entry    = {pc_in, inst_in};
  assign iqueue_full = (count >= FULL_MARK);

  always_comb begin
    rd             = inst_valid && !iss_stall;
    wr             = inst_rdy && (count != DEPTH_C);
    head_nxt       = head + DEPTH_LOG'(rd);
    count_after_rd = count - (DEPTH_LOG+1)'(rd);
    count_nxt      = count_after_rd + (DEPTH_LOG+1)'(wr);
    // When nothing else remains after the read, the new head is this cycle's write.
    load_entry     = (count_after_rd == '0) ? in_entry : ram_rdata;
`ifdef IQUEUE_BYPASS_EN
    load           = (!inst_valid || !iss_stall) && (count_nxt != '0);
    ram_we         = wr && (count_after_rd != '0);
`else
    load           = rd ? (count_nxt != '0) : (!inst_valid && (count != '0));
    ram_we         = wr;
`endif
  end

  iq_ram #(.DEPTH_LOG(DEPTH_LOG)) u_ram (
    .clk   (clk),
    .we    (ram_we && rdy && !rst && !flush),
    .waddr (tail),
    .wdata (in_entry),
    .raddr (head_nxt),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      pc_out     <= '0;
      fetch_pc   <= '0;
    end else if (rdy) begin
      fetch_pc <= br_done ? br_target : 32'h0;
      if (flush) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        inst_valid <= 1'b0;
      end else begin
        head  <= head_nxt;
        tail  <= tail + DEPTH_LOG'(wr);
        count <= count_nxt;
        if (load) begin
          inst_valid <= 1'b1;
          inst_out   <= load_entry[IQ_PC_LSB-1:0];
          pc_out     <= load_entry[IQ_ENTRY_W-1:IQ_PC_LSB];
        end else if (rd) begin
          inst_valid <= 1'b0;
        end
      end
    end
  end

endmodule
